// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller behind the pipeline's Memory stage.
// Turns load/store requests into valid/ready bus transactions, holds the
// pipeline with stall until each access finishes, masks disabled byte
// lanes out of load data and abandons accesses that exceed a cycle budget.
module dmem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        byte_en,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int LANE_W = DATA_W / 4;
    localparam int CNT_W  = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [CNT_W-1:0]    r_count;
    logic                r_busValid;
    logic                r_busWe;
    logic [ADDR_W-1:0]   r_busAddr;
    logic [DATA_W-1:0]   r_busWdata;
    logic [3:0]          r_busBe;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_req;
    logic                w_terminal;
    logic                w_start;
    logic                w_zeroBe;
    logic                w_accept;
    logic                w_capture;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_maskedRdata;
    logic                w_unusedAddrBits;

    // The bus address is always word aligned, so the low address bits only
    // matter to the byte enables the stage already computed.
    assign w_unusedAddrBits = ^addr[1:0];

    assign w_req      = mem_read | mem_write;
    assign w_terminal = (r_count == CNT_TERM);

    // Hold the pipeline for every cycle of a pending access except the
    // single completion cycle, which lets the instruction move on.
    assign stall = w_req && (r_state != S_DONE);

    assign rdata     = r_rdata;
    assign err       = r_err;
    assign bus_valid = r_busValid;
    assign bus_we    = r_busWe;
    assign bus_addr  = r_busAddr;
    assign bus_wdata = r_busWdata;
    assign bus_be    = r_busBe;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the one-cycle events the datapath acts on;
    // a progress event always beats the terminal count in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_zeroBe    = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (byte_en != 4'b0000) begin
                        w_start     = 1'b1;
                        w_nextState = S_ADDR;
                    end else begin
                        w_zeroBe    = 1'b1;
                        w_nextState = S_DONE;
                    end
                end
            end
            S_ADDR: begin
                if (bus_ready) begin
                    w_accept    = 1'b1;
                    w_nextState = r_busWe ? S_DONE : S_WAIT;
                end else if (w_terminal) begin
                    w_timeout   = 1'b1;
                    w_nextState = S_DONE;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    w_capture   = 1'b1;
                    w_nextState = S_DONE;
                end else if (w_terminal) begin
                    w_timeout   = 1'b1;
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Zero every byte lane of returned data whose enable was not set.
    always_comb begin
        w_maskedRdata = '0;
        for (int i = 0; i < 4; i++) begin
            w_maskedRdata[i*LANE_W +: LANE_W] =
                bus_rdata[i*LANE_W +: LANE_W] & {LANE_W{r_busBe[i]}};
        end
    end

    // Bus request fields: latched once when an access starts so they stay
    // stable under backpressure; valid drops after acceptance or timeout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busValid <= 1'b0;
            r_busWe    <= 1'b0;
            r_busAddr  <= '0;
            r_busWdata <= '0;
            r_busBe    <= 4'b0000;
        end else if (w_start) begin
            r_busValid <= 1'b1;
            r_busWe    <= mem_write;
            r_busAddr  <= {addr[ADDR_W-1:2], 2'b00};
            r_busWdata <= wdata;
            r_busBe    <= byte_en;
        end else if (w_accept || w_timeout) begin
            r_busValid <= 1'b0;
        end
    end

    // Timeout counter: cleared at access start, counts every ADDR/WAIT cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= '0;
        end else if ((r_state == S_ADDR) || (r_state == S_WAIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Load data and error pulse: captured data is held until the next load
    // completes; aborted or lane-less accesses return zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_capture) begin
                r_rdata <= w_maskedRdata;
            end else if (w_timeout || w_zeroBe) begin
                r_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl. One instance uses
// the default timeout budget, a second uses TIMEOUT=4 for the abort cases.
module tb_dmem_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    logic [31:0] rdata;
    logic        stall;
    logic        err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;

    logic [31:0] tRdata;
    logic        tStall;
    logic        tErr;
    logic        tBusValid;
    logic        tBusWe;
    logic [31:0] tBusAddr;
    logic [31:0] tBusWdata;
    logic [3:0]  tBusBe;

    int testsRun;
    int testsFailed;
    int stalls;
    logic sawValid;

    dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .byte_en(byte_en),
        .rdata(rdata), .stall(stall), .err(err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dutT (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .byte_en(byte_en),
        .rdata(tRdata), .stall(tStall), .err(tErr),
        .bus_valid(tBusValid), .bus_ready(bus_ready), .bus_we(tBusWe),
        .bus_addr(tBusAddr), .bus_wdata(tBusWdata), .bus_be(tBusBe),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present a Memory-stage request on the shared inputs.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] be);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        byte_en   = be;
    endtask

    // Hold reset low for two rising edges with the request inputs idle.
    task automatic resetBoth();
        reset      = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Step one access cycle by cycle from its IDLE cycle (k=0), pulsing
    // bus_ready/bus_rvalid at the given cycles, counting stall cycles and
    // checking the request fields for every cycle the request is pending.
    task automatic runAccess(input int readyCycle, input int rvalidCycle,
                             input logic [31:0] rdataIn, input logic [31:0] expAddr,
                             input logic [31:0] expWdata, input logic [3:0] expBe,
                             input logic expWe, output int stallCount,
                             output logic validSeen);
        logic finished;
        finished   = 1'b0;
        stallCount = 0;
        validSeen  = 1'b0;
        for (int k = 0; k < 40 && !finished; k++) begin
            bus_ready  = (k == readyCycle);
            bus_rvalid = (k == rvalidCycle);
            bus_rdata  = rdataIn;
            #1;
            validSeen = validSeen | bus_valid;
            if (k == 0) begin
                checkOutput("idleValid", {31'b0, bus_valid}, 32'h0);
            end
            if (k >= 1 && k <= readyCycle) begin
                checkOutput("reqValid", {31'b0, bus_valid}, 32'h1);
                checkOutput("reqAddr", bus_addr, expAddr);
                checkOutput("reqWdata", bus_wdata, expWdata);
                checkOutput("reqBe", {28'b0, bus_be}, {28'b0, expBe});
                checkOutput("reqWe", {31'b0, bus_we}, {31'b0, expWe});
            end
            if (stall) begin
                stallCount++;
                @(negedge clk);
            end else begin
                finished = 1'b1;
            end
        end
        checkOutput("accessDone", {31'b0, finished}, 32'h1);
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    // Directed test sequence.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        bus_rdata   = 32'h0;
        resetBoth();
        #1;
        checkOutput("rstStall", {31'b0, stall}, 32'h0);
        checkOutput("rstValid", {31'b0, bus_valid}, 32'h0);
        checkOutput("rstErr", {31'b0, err}, 32'h0);
        checkOutput("rstRdata", rdata, 32'h0);
        checkOutput("rstAddr", bus_addr, 32'h0);
        checkOutput("rstBe", {28'b0, bus_be}, 32'h0);
        checkOutput("rstWe", {31'b0, bus_we}, 32'h0);

        // Store with immediate acceptance.
        applyStimulus(1'b0, 1'b1, 32'h0000_1006, 32'hA1B2_C3D4, 4'b1111);
        runAccess(1, -1, 32'h0, 32'h0000_1004, 32'hA1B2_C3D4, 4'b1111, 1'b1, stalls, sawValid);
        checkOutput("stStalls", stalls, 32'd2);
        checkOutput("stErr", {31'b0, err}, 32'h0);
        checkOutput("stDoneValid", {31'b0, bus_valid}, 32'h0);
        checkOutput("stRdata", rdata, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);

        // Half-word load: accepted on the second ADDR cycle, data three later.
        applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b0011);
        runAccess(2, 5, 32'h1122_3344, 32'h0000_0020, 32'h0, 4'b0011, 1'b0, stalls, sawValid);
        checkOutput("ldStalls", stalls, 32'd6);
        checkOutput("ldRdata", rdata, 32'h0000_3344);
        checkOutput("ldErr", {31'b0, err}, 32'h0);
        checkOutput("ldDoneValid", {31'b0, bus_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        checkOutput("ldHold", rdata, 32'h0000_3344);

        // Store under five cycles of backpressure.
        applyStimulus(1'b0, 1'b1, 32'h0000_2003, 32'h55AA_0FF0, 4'b1100);
        runAccess(6, -1, 32'h0, 32'h0000_2000, 32'h55AA_0FF0, 4'b1100, 1'b1, stalls, sawValid);
        checkOutput("bpStalls", stalls, 32'd7);
        checkOutput("bpErr", {31'b0, err}, 32'h0);
        checkOutput("bpRdataKept", rdata, 32'h0000_3344);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);

        // Load with no byte lanes enabled never touches the bus.
        applyStimulus(1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'b0000);
        runAccess(-1, -1, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'h0, 1'b0, stalls, sawValid);
        checkOutput("zbStalls", stalls, 32'd1);
        checkOutput("zbNoValid", {31'b0, sawValid}, 32'h0);
        checkOutput("zbRdata", rdata, 32'h0);
        checkOutput("zbErr", {31'b0, err}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);

        // Load a known word so the timeout's zeroing is visible.
        resetBoth();
        applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'b1111);
        runAccess(1, 2, 32'hCAFE_F00D, 32'h0000_0044, 32'h0, 4'b1111, 1'b0, stalls, sawValid);
        checkOutput("preStalls", stalls, 32'd3);
        checkOutput("preRdataT", tRdata, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);

        // TIMEOUT=4 instance: load never accepted, aborted after 4 ADDR cycles.
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b1111);
        bus_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("toStall", {31'b0, tStall}, 32'h1);
            checkOutput("toErrLow", {31'b0, tErr}, 32'h0);
            if (k >= 1) begin
                checkOutput("toValid", {31'b0, tBusValid}, 32'h1);
            end
            if (k == 1) begin
                checkOutput("toAddr", tBusAddr, 32'h0000_0040);
                checkOutput("toWe", {31'b0, tBusWe}, 32'h0);
                checkOutput("toBe", {28'b0, tBusBe}, 32'h0000_000F);
                checkOutput("toWdata", tBusWdata, 32'h0);
            end
            @(negedge clk);
        end
        #1;
        checkOutput("toDoneStall", {31'b0, tStall}, 32'h0);
        checkOutput("toErr", {31'b0, tErr}, 32'h1);
        checkOutput("toDoneValid", {31'b0, tBusValid}, 32'h0);
        checkOutput("toRdata", tRdata, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        checkOutput("toErrPulse", {31'b0, tErr}, 32'h0);

        // Acceptance on the terminal count beats the timeout.
        resetBoth();
        applyStimulus(1'b1, 1'b0, 32'h0000_0050, 32'h0, 4'b1111);
        runAccess(4, 5, 32'h0BAD_CAFE, 32'h0000_0050, 32'h0, 4'b1111, 1'b0, stalls, sawValid);
        checkOutput("termStalls", stalls, 32'd6);
        checkOutput("termErrT", {31'b0, tErr}, 32'h0);
        checkOutput("termRdataT", tRdata, 32'h0BAD_CAFE);
        checkOutput("termStallT", {31'b0, tStall}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);

        // Reset during WAIT abandons the load; late read data is ignored.
        applyStimulus(1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'b1111);
        bus_ready = 1'b0;
        @(negedge clk);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFF_FFFF;
        #1;
        checkOutput("mrValid", {31'b0, bus_valid}, 32'h0);
        checkOutput("mrStall", {31'b0, stall}, 32'h0);
        checkOutput("mrRdata", rdata, 32'h0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        checkOutput("mrRdataLate", rdata, 32'h0);
        checkOutput("mrErr", {31'b0, err}, 32'h0);
        checkOutput("mrValidLate", {31'b0, bus_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller downstream of the pipelined ARM datapath's Memory stage.
- Consumes the stage's address, write data, byte enables and read/write strobes; drives a valid/ready memory bus; returns load data.
- Holds `stall` high so the hazard unit freezes the pipeline until each access completes.
- Adds byte-lane masking of load data and a bus timeout with an error flag.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 4 byte lanes)
- TIMEOUT, 16, max cycles spent in ADDR+WAIT before forced completion (>=2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- mem_read  in  1  load request from Memory stage
- mem_write  in  1  store request from Memory stage (wins if both high)
- addr  in  ADDR_W  byte address (ALU result)
- wdata  in  DATA_W  store data
- byte_en  in  4  byte-lane enables
- rdata  out  DATA_W  load data, valid in DONE cycle
- stall  out  1  pipeline hold
- err  out  1  one-cycle pulse: access timed out
- bus_valid  out  1  request valid
- bus_ready  in  1  request accepted
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address
- bus_wdata  out  DATA_W  write data
- bus_be  out  4  byte enables
- bus_rvalid  in  1  read data valid
- bus_rdata  in  DATA_W  read data

Behaviour:
- req = mem_read | mem_write.
- States: IDLE, ADDR, WAIT, DONE.
- Reset (reset==0 at clk edge): state IDLE; bus_valid, bus_we, err, stall-reg, timeout counter = 0; rdata = 0; bus_addr/bus_wdata/bus_be = 0.
- Reset mid-access abandons the transaction; bus_valid is 0 from the next cycle; late bus_rvalid is ignored.
- stall (combinational) = req && state != DONE. It is 0 in IDLE with no request.
- IDLE, req, byte_en != 0:
  - latch bus_addr = {addr[ADDR_W-1:2], 2'b00}, bus_wdata = wdata, bus_be = byte_en, bus_we = mem_write;
  - clear counter; go to ADDR.
- IDLE, req, byte_en == 0: no bus transaction; go to DONE; rdata = 0.
- ADDR: bus_valid = 1; request fields stable while bus_valid && !bus_ready.
  - bus_ready=1: store goes to DONE; load goes to WAIT.
  - bus_valid drops the cycle after acceptance.
- WAIT: bus_rvalid=1 → capture rdata = bus_rdata with disabled lanes (bus_be[i]==0) forced to 0x00; go to DONE.
  - bus_rvalid in the same cycle as bus_ready is not legal; the bus guarantees at least one cycle of separation.
- Timeout:
  - Counter increments each cycle in ADDR or WAIT.
  - At count == TIMEOUT-1 with no progress event that cycle: go to DONE, bus_valid = 0, rdata = 0, err = 1 during DONE.
  - A progress event in the same cycle as the terminal count wins: normal completion, no err.
- DONE: exactly one cycle. stall = 0, so the pipeline advances. rdata is held until the next load's DONE. Next state IDLE.
- A new request presented in the cycle after DONE is processed normally.
- Latency:
  - Store with immediate ready: 2 stall cycles (IDLE, ADDR), then DONE.
  - Load with ready in ADDR and rvalid one cycle later: 3 stall cycles.
- Store data for stores is not returned; rdata is unchanged by stores.
- err is 0 in every state except timed-out DONE.

Test Plan:
1. Store:
   - Stimulus: reset low 2 cycles, then mem_write=1, addr=0x0000_1006, wdata=0xA1B2C3D4, byte_en=4'b1111, bus_ready=1.
   - Response: bus_valid 1 cycle later with bus_addr=0x0000_1004, bus_we=1; stall high 2 cycles then low; err=0.
2. Load:
   - Stimulus: mem_read=1, addr=0x20, byte_en=4'b0011, bus_ready after 2 ADDR cycles, bus_rvalid 3 cycles later with bus_rdata=0x11223344.
   - Response: rdata=0x00003344 in DONE; stall high exactly 6 cycles.
3. Backpressure:
   - Stimulus: bus_ready held 0 for 5 cycles with TIMEOUT=16.
   - Response: bus_addr, bus_wdata and bus_be unchanged throughout; completes normally; err=0.
4. Timeout:
   - Stimulus: TIMEOUT=4, load with bus_ready never asserted.
   - Response: DONE after 4 ADDR cycles; err pulses 1 cycle; rdata=0; bus_valid=0 in DONE.
5. Zero byte enables:
   - Stimulus: mem_read=1, byte_en=0.
   - Response: no bus_valid; stall 1 cycle; rdata=0.
6. Reset mid-access:
   - Stimulus: reset=0 during WAIT, then bus_rvalid=1 with bus_rdata=0xFFFFFFFF.
   - Response: state IDLE, rdata stays 0, stall=0 with mem_read low.
